// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: access-size encodings,
// FSM state type and the size/extension helper functions.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SPLIT2 = 1'b1
  } state_e;

  // Number of bytes moved by an access of the given size encoding.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    size_bytes = 4'd1;
      SZ_H:    size_bytes = 4'd2;
      SZ_W:    size_bytes = 4'd4;
      SZ_D:    size_bytes = 4'd8;
      default: size_bytes = 4'd1;
    endcase
  endfunction

  // Sign- or zero-extend the low bytes of data; a D access is returned as-is.
  function automatic logic [63:0] extend(input logic [63:0] data,
                                         input logic [1:0]  size,
                                         input logic        is_unsigned);
    case (size)
      SZ_B:    extend = is_unsigned ? {56'd0, data[7:0]}  : {{56{data[7]}},  data[7:0]};
      SZ_H:    extend = is_unsigned ? {48'd0, data[15:0]} : {{48{data[15]}}, data[15:0]};
      SZ_W:    extend = is_unsigned ? {32'd0, data[31:0]} : {{32{data[31]}}, data[31:0]};
      SZ_D:    extend = data;
      default: extend = data;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic. An access is viewed as a window over two
// consecutive words (lo, hi) so that the same shifter serves both aligned
// accesses (hi half stays empty) and word-crossing accesses.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int LANE_W = $clog2(XLEN / 8)
) (
  input  logic [LANE_W-1:0]  lane,
  input  logic [1:0]         size,
  input  logic               is_unsigned,
  input  logic [XLEN-1:0]    wdata,
  input  logic [XLEN-1:0]    rword_lo,
  input  logic [XLEN-1:0]    rword_hi,
  output logic [XLEN/8-1:0]  be_lo,
  output logic [XLEN/8-1:0]  be_hi,
  output logic [XLEN-1:0]    wd_lo,
  output logic [XLEN-1:0]    wd_hi,
  output logic [XLEN-1:0]    rdata
);

  localparam int BYTES = XLEN / 8;

  logic [2*BYTES-1:0] be2_s;
  logic [2*XLEN-1:0]  wd2_s;
  logic [2*XLEN-1:0]  rd2_s;
  logic [63:0]        ext_in_s;
  logic [63:0]        ext_out_s;
  logic [4:0]         lo_s;
  logic [4:0]         hi_s;

  // Byte enables cover lanes [lane, lane+size) across the two-word window.
  always_comb begin
    lo_s  = 5'(lane);
    hi_s  = 5'(lane) + 5'(size_bytes(size));
    be2_s = '0;
    for (int b = 0; b < 2 * BYTES; b++) begin
      if ((5'(b) >= lo_s) && (5'(b) < hi_s)) begin
        be2_s[b] = 1'b1;
      end else begin
        be2_s[b] = 1'b0;
      end
    end
  end

  // Shift store data up to its lane and load data down from its lane.
  always_comb begin
    wd2_s     = {{XLEN{1'b0}}, wdata} << {lane, 3'b000};
    rd2_s     = {rword_hi, rword_lo} >> {lane, 3'b000};
    ext_in_s  = 64'(rd2_s[XLEN-1:0]);
    ext_out_s = extend(ext_in_s, size, is_unsigned);
  end

  assign be_lo = be2_s[BYTES-1:0];
  assign be_hi = be2_s[2*BYTES-1:BYTES];
  assign wd_lo = wd2_s[XLEN-1:0];
  assign wd_hi = wd2_s[2*XLEN-1:XLEN];
  assign rdata = ext_out_s[XLEN-1:0];

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressable data memory for the MEM stage with registered response.
// Optional feature macro DMEM_MISALIGN_SPLIT_EN: misaligned accesses are
// served (word-crossing ones in two beats) instead of faulting.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 64,
  parameter int INIT_ZERO   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault
);

  localparam int BYTES  = XLEN / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0]   MEM_BYTES_C = (ADDR_W + 1)'(DEPTH_WORDS * BYTES);
  localparam logic [XLEN-1:0]   INIT_WORD_C = (INIT_ZERO != 0) ? {XLEN{1'b0}} : {XLEN{1'bx}};

  // Storage has no reset; the declaration value is only a time-0 initialiser.
  logic [XLEN-1:0] mem_r [DEPTH_WORDS] = '{default: INIT_WORD_C};

  state_e            state_r, state_nx_s;
  logic              rsp_valid_r, rsp_fault_r;
  logic [XLEN-1:0]   rsp_rdata_r;
  // Context of a word-crossing access held across the second beat.
  logic [LANE_W-1:0] lane_q_r;
  logic [1:0]        size_q_r;
  logic              uns_q_r, we_q_r;
  logic [XLEN-1:0]   wdata_q_r, hold_r;
  logic [IDX_W-1:0]  idx_q_r;

  logic [LANE_W-1:0] lane_s, al_lane_s;
  logic [IDX_W-1:0]  idx_s, widx_s;
  logic [3:0]        nbytes_s;
  logic [ADDR_W:0]   end_s;
  logic              oor_s, bad_size_s, misal_s, fault_s, split_s;
  logic              accept_s, in_split_s, wen_s, rsp_set_s, fault_nx_s;
  logic [1:0]        al_size_s;
  logic              al_uns_s;
  logic [XLEN-1:0]   al_wdata_s, al_lo_s, al_hi_s, al_rdata_s, rdata_nx_s;
  logic [XLEN-1:0]   wd_lo_s, wd_hi_s, wwd_s;
  logic [BYTES-1:0]  be_lo_s, be_hi_s, wbe_s;

  assign lane_s     = req_addr[LANE_W-1:0];
  assign idx_s      = req_addr[LANE_W +: IDX_W];
  assign in_split_s = (state_r == ST_SPLIT2);
  assign accept_s   = req_valid && req_ready;

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic cross_s;
  assign cross_s   = (5'(lane_s) + 5'(nbytes_s)) > 5'(BYTES);
  assign req_ready = (state_r == ST_IDLE);
`else
  assign req_ready = 1'b1;
`endif

  // Classify the incoming request: range, size legality and alignment.
  always_comb begin
    nbytes_s   = size_bytes(req_size);
    end_s      = {1'b0, req_addr} + (ADDR_W + 1)'(nbytes_s);
    oor_s      = (end_s > MEM_BYTES_C);
    bad_size_s = (XLEN == 32) && (req_size == SZ_D);
    misal_s    = (req_addr[3:0] & (nbytes_s - 4'd1)) != 4'd0;
`ifdef DMEM_MISALIGN_SPLIT_EN
    fault_s    = oor_s || bad_size_s;
    split_s    = !fault_s && misal_s && cross_s;
`else
    fault_s    = oor_s || bad_size_s || misal_s;
    split_s    = 1'b0;
`endif
  end

  // Feed the lane aligner from the live request or the held second-beat context.
  always_comb begin
    if (in_split_s) begin
      al_lane_s  = lane_q_r;
      al_size_s  = size_q_r;
      al_uns_s   = uns_q_r;
      al_wdata_s = wdata_q_r;
      al_lo_s    = hold_r;
      al_hi_s    = mem_r[idx_q_r];
    end else begin
      al_lane_s  = lane_s;
      al_size_s  = req_size;
      al_uns_s   = req_unsigned;
      al_wdata_s = req_wdata;
      al_lo_s    = mem_r[idx_s];
      al_hi_s    = mem_r[idx_s + IDX_W'(1'b1)];
    end
  end

  dmem_lane_align #(.XLEN(XLEN), .LANE_W(LANE_W)) u_align (
    .lane        (al_lane_s),
    .size        (al_size_s),
    .is_unsigned (al_uns_s),
    .wdata       (al_wdata_s),
    .rword_lo    (al_lo_s),
    .rword_hi    (al_hi_s),
    .be_lo       (be_lo_s),
    .be_hi       (be_hi_s),
    .wd_lo       (wd_lo_s),
    .wd_hi       (wd_hi_s),
    .rdata       (al_rdata_s)
  );

  // Single write port: first (or only) beat at acceptance, upper beat in SPLIT2.
  always_comb begin
    wen_s  = 1'b0;
    widx_s = idx_s;
    wbe_s  = be_lo_s;
    wwd_s  = wd_lo_s;
    if (rst) begin
      wen_s = 1'b0;
    end else if (in_split_s) begin
      wen_s  = we_q_r;
      widx_s = idx_q_r;
      wbe_s  = be_hi_s;
      wwd_s  = wd_hi_s;
    end else if (accept_s && req_we && !fault_s) begin
      wen_s = 1'b1;
    end else begin
      wen_s = 1'b0;
    end
  end

  // Next response value; stores and faults return zero data.
  always_comb begin
    rsp_set_s  = 1'b0;
    fault_nx_s = 1'b0;
    rdata_nx_s = '0;
    if (in_split_s) begin
      rsp_set_s  = 1'b1;
      rdata_nx_s = we_q_r ? '0 : al_rdata_s;
    end else if (accept_s) begin
      if (fault_s) begin
        rsp_set_s  = 1'b1;
        fault_nx_s = 1'b1;
      end else if (split_s) begin
        rsp_set_s = 1'b0;
      end else begin
        rsp_set_s  = 1'b1;
        rdata_nx_s = req_we ? '0 : al_rdata_s;
      end
    end else begin
      rsp_set_s = 1'b0;
    end
  end

  // Next-state logic: only a word-crossing access leaves IDLE.
  always_comb begin
    state_nx_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && split_s) begin
          state_nx_s = ST_SPLIT2;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SPLIT2: state_nx_s = ST_IDLE;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nx_s;
  end

  // Response registers; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_fault_r <= 1'b0;
      rsp_rdata_r <= '0;
    end else begin
      rsp_valid_r <= rsp_set_s;
      rsp_fault_r <= fault_nx_s;
      rsp_rdata_r <= rdata_nx_s;
    end
  end

  // Capture the crossing access context and the low word for the second beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q_r  <= '0;
      size_q_r  <= SZ_B;
      uns_q_r   <= 1'b0;
      we_q_r    <= 1'b0;
      wdata_q_r <= '0;
      hold_r    <= '0;
      idx_q_r   <= '0;
    end else if (accept_s && split_s) begin
      lane_q_r  <= lane_s;
      size_q_r  <= req_size;
      uns_q_r   <= req_unsigned;
      we_q_r    <= req_we;
      wdata_q_r <= req_wdata;
      hold_r    <= mem_r[idx_s];
      idx_q_r   <= idx_s + IDX_W'(1'b1);
    end
  end

  // Byte-lane write into storage.
  always_ff @(posedge clk) begin
    if (wen_s) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wbe_s[b]) mem_r[widx_s][8*b +: 8] <= wwd_s[8*b +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_fault = rsp_fault_r;

endmodule
